// File: rtl/counter_pkg.sv
// Purpose: shared types and constants for the programmable event counter.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package counter_pkg;

    // Width of the exported count bus.
    localparam int COUNTER_OUT_W = 32;

    // Counter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } counter_state_e;

endpackage : counter_pkg

// File: rtl/counter_unit.sv
// Purpose: counts enabled cycles up to a programmable target, flags done and word-aligned counts.
// Latency: one cycle from a sampled enable to counter_out; done and words follow the same edge.
// Backpressure: none; counter_en is sampled every edge and ignored while DONE (default build).
// Optional feature: define COUNTER_AUTO_RESTART_EN to restart counting from 1 on an enable in DONE.
module counter_unit
    import counter_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     counter_en,
    input  logic [WIDTH-1:0]         counter_N,
    output logic [COUNTER_OUT_W-1:0] counter_out,
    output logic                     counter_done,
    output logic                     counter_words
);

    counter_state_e   state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;

    // Incremented count carries one spare bit so the target compare never wraps.
    logic [WIDTH:0]   count_inc;
    logic             target_zero;
    logic             target_reached;
    logic             target_below;

    assign count_inc      = {1'b0, count_q} + (WIDTH+1)'(1);
    assign target_zero    = (counter_N == '0);
    assign target_reached = (count_inc >= {1'b0, counter_N});
    assign target_below   = (counter_N <= count_q);

    // State and count registers; reset clears both asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and next-count logic; a zero target always wins over enable.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (target_zero) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The edge that leaves IDLE does not count; counting starts in COUNT.
                    state_d = COUNT;
                    count_d = '0;
                end
                COUNT: begin
                    if (target_below) begin
                        // Target was lowered to or under the current count: finish without incrementing.
                        state_d = DONE;
                    end else if (counter_en) begin
                        count_d = count_inc[WIDTH-1:0];
                        if (target_reached) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef COUNTER_AUTO_RESTART_EN
                    if (counter_en) begin
                        count_d = WIDTH'(1);
                        // A target of one is already met by the restarted count.
                        state_d = (counter_N == WIDTH'(1)) ? DONE : COUNT;
                    end
`else
                    // Sticky until the target is cleared or reset is applied.
                    state_d = DONE;
`endif
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Outputs decode directly from registers, so they change only after an edge or reset.
    always_comb begin
        counter_out   = COUNTER_OUT_W'(count_q);
        counter_done  = (state_q == DONE);
        counter_words = (count_q[1:0] == 2'b00) && (count_q != '0);
    end

endmodule : counter_unit

// File: tb/tb_counter_unit.sv
// Purpose: directed self-checking bench for counter_unit in its default build.
// Latency: inputs change 1ns after a rising edge; outputs are sampled 1ns after the next edge.
// Backpressure: not applicable.
module tb_counter_unit;

    localparam int WIDTH = 7;

    logic             clk;
    logic             rstn;
    logic             counter_en;
    logic [WIDTH-1:0] counter_N;
    logic [31:0]      counter_out;
    logic             counter_done;
    logic             counter_words;

    int total;
    int bad;

    counter_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .counter_en   (counter_en),
        .counter_N    (counter_N),
        .counter_out  (counter_out),
        .counter_done (counter_done),
        .counter_words(counter_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        counter_en = 1'b1;
        counter_N  = 7'd14;
        #2;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (counter_out !== 32'd0) begin
                bad++;
                $display("FAIL reset_out cycle %0d: got %0d want 0", c, counter_out);
            end
            total++;
            if (counter_done !== 1'b0 || counter_words !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags cycle %0d: got done=%b words=%b want 0 0",
                         c, counter_done, counter_words);
            end
        end
        counter_en = 1'b0;
        rstn       = 1'b1;
    endtask

    task automatic test_basic_count();
        logic exp_words;
        // Leave IDLE with N=14 already applied.
        tick();
        total++;
        if (counter_out !== 32'd0 || counter_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_start: got out=%0d done=%b want 0 0", counter_out, counter_done);
        end
        for (int i = 1; i <= 14; i++) begin
            counter_en = 1'b1;
            tick();
            counter_en = 1'b0;
            exp_words = (i == 4) || (i == 8) || (i == 12);
            total++;
            if (counter_out !== 32'(i)) begin
                bad++;
                $display("FAIL basic_out pulse %0d: got %0d want %0d", i, counter_out, i);
            end
            total++;
            if (counter_words !== exp_words) begin
                bad++;
                $display("FAIL basic_words pulse %0d: got %b want %b", i, counter_words, exp_words);
            end
            total++;
            if (counter_done !== (i == 14)) begin
                bad++;
                $display("FAIL basic_done pulse %0d: got %b want %b", i, counter_done, (i == 14));
            end
            tick();
            tick();
        end
    endtask

    task automatic test_hold_clear();
        for (int i = 0; i < 3; i++) begin
            counter_en = 1'b1;
            tick();
            counter_en = 1'b0;
            tick();
            total++;
            if (counter_out !== 32'd14 || counter_done !== 1'b1) begin
                bad++;
                $display("FAIL hold pulse %0d: got out=%0d done=%b want 14 1", i, counter_out, counter_done);
            end
        end
        counter_N = 7'd0;
        tick();
        total++;
        if (counter_out !== 32'd0 || counter_done !== 1'b0 || counter_words !== 1'b0) begin
            bad++;
            $display("FAIL clear: got out=%0d done=%b words=%b want 0 0 0",
                     counter_out, counter_done, counter_words);
        end
    endtask

    task automatic test_continuous();
        counter_N = 7'd5;
        tick();
        counter_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (counter_out !== 32'(i) || counter_done !== (i == 5)) begin
                bad++;
                $display("FAIL continuous edge %0d: got out=%0d done=%b want %0d %b",
                         i, counter_out, counter_done, i, (i == 5));
            end
        end
        counter_en = 1'b0;
        counter_N  = 7'd0;
        tick();
    endtask

    task automatic test_target_lowered();
        counter_N = 7'd20;
        tick();
        counter_en = 1'b1;
        repeat (10) tick();
        counter_en = 1'b0;
        total++;
        if (counter_out !== 32'd10 || counter_done !== 1'b0) begin
            bad++;
            $display("FAIL lower_pre: got out=%0d done=%b want 10 0", counter_out, counter_done);
        end
        counter_N = 7'd8;
        tick();
        total++;
        if (counter_out !== 32'd10 || counter_done !== 1'b1) begin
            bad++;
            $display("FAIL lower_done: got out=%0d done=%b want 10 1", counter_out, counter_done);
        end
        counter_N = 7'd0;
        tick();
    endtask

    task automatic test_async_reset();
        counter_N = 7'd14;
        tick();
        counter_en = 1'b1;
        repeat (7) tick();
        counter_en = 1'b0;
        total++;
        if (counter_out !== 32'd7 || counter_words !== 1'b0) begin
            bad++;
            $display("FAIL async_pre: got out=%0d words=%b want 7 0", counter_out, counter_words);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (counter_out !== 32'd0 || counter_done !== 1'b0 || counter_words !== 1'b0) begin
            bad++;
            $display("FAIL async_mid: got out=%0d done=%b words=%b want 0 0 0",
                     counter_out, counter_done, counter_words);
        end
        tick();
        rstn = 1'b1;
        tick();
        counter_en = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            total++;
            if (counter_out !== 32'(i)) begin
                bad++;
                $display("FAIL async_resume edge %0d: got %0d want %0d", i, counter_out, i);
            end
        end
        counter_en = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rstn       = 1'b0;
        counter_en = 1'b0;
        counter_N  = '0;
        test_reset();
        test_basic_count();
        test_hold_clear();
        test_continuous();
        test_target_lowered();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_counter_unit
